// File: rtl/cache_sram.sv
// cache_sram: simple dual-port synchronous RAM (one write port, one read port,
// one clock). The read data is registered, giving one cycle of latency. When the
// read and the write hit the same address, the read returns the old contents.
// The storage has no reset, so synthesis can map it onto block RAM.
module cache_sram #(
    parameter int width   = 8,
    parameter int widthad = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [widthad-1:0] wraddress,
    input  logic               wren,
    input  logic [width-1:0]   data,
    input  logic [widthad-1:0] rdaddress,
    output logic [width-1:0]   q
);

    localparam int DEPTH = 2 ** widthad;

    // Storage is never cleared. Simulation can preload it through the hierarchy.
    logic [width-1:0] mem [0:DEPTH-1];

    // Write port and registered read port. The nonblocking assignments give
    // read-before-write on an address collision, which the tag logic relies on
    // when it reads an entry and rewrites it in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            if (wren) begin
                mem[wraddress] <= data;
            end
            q <= mem[rdaddress];
        end
    end

endmodule

// File: tb/tb_cache_sram.sv
// Scoreboard bench for cache_sram. It instantiates a byte-lane configuration
// (8 bits x 16 entries) and a tag-array configuration (11 bits x 16384 entries).
// Each stimulus step pushes its expected q into a queue. A monitor pops that
// entry and compares it with q on the following falling edge.
module tb_cache_sram;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  wa_a = '0, ra_a = '0;
    logic        wren_a = 1'b0;
    logic [7:0]  d_a = '0;
    logic [7:0]  q_a;

    logic [13:0] wa_b = '0, ra_b = '0;
    logic        wren_b = 1'b0;
    logic [10:0] d_b = '0;
    logic [10:0] q_b;

    bit chk_a = 1'b0, chk_b = 1'b0;
    bit pend_a = 1'b0, pend_b = 1'b0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_sram #(.width(8), .widthad(4)) u_a (
        .clk(clk), .rst(rst), .wraddress(wa_a), .wren(wren_a),
        .data(d_a), .rdaddress(ra_a), .q(q_a)
    );

    cache_sram #(.width(11), .widthad(14)) u_b (
        .clk(clk), .rst(rst), .wraddress(wa_b), .wren(wren_b),
        .data(d_b), .rdaddress(ra_b), .q(q_b)
    );

    // Mark the cycles whose captured q must be checked.
    always @(posedge clk) begin
        pend_a <= chk_a;
        pend_b <= chk_b;
    end

    // Monitor for the byte-lane RAM.
    always @(negedge clk) begin
        if (pend_a) begin
            n_cmp++;
            if (sb_a.size() == 0) begin
                n_bad++;
                $display("FAIL a_underflow: q=%h with no expected entry", q_a);
            end else begin
                exp_t e;
                e = sb_a.pop_front();
                if (q_a !== e.exp[7:0]) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, q_a, e.exp[7:0]);
                end
            end
        end
    end

    // Monitor for the tag RAM.
    always @(negedge clk) begin
        if (pend_b) begin
            n_cmp++;
            if (sb_b.size() == 0) begin
                n_bad++;
                $display("FAIL b_underflow: q=%h with no expected entry", q_b);
            end else begin
                exp_t e;
                e = sb_b.pop_front();
                if (q_b !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, q_b, e.exp);
                end
            end
        end
    end

    task automatic step_a(input string nm, input logic r, input logic we,
                          input logic [3:0] wa, input logic [7:0] d,
                          input logic [3:0] ra, input logic [7:0] exp);
        exp_t e;
        rst = r; wren_a = we; wa_a = wa; d_a = d; ra_a = ra;
        e.name = nm; e.exp = {3'b000, exp};
        sb_a.push_back(e);
        chk_a = 1'b1;
        @(posedge clk); #1;
        chk_a = 1'b0;
    endtask

    task automatic step_b(input string nm, input logic we,
                          input logic [13:0] wa, input logic [10:0] d,
                          input logic [13:0] ra, input logic [10:0] exp);
        exp_t e;
        wren_b = we; wa_b = wa; d_b = d; ra_b = ra;
        e.name = nm; e.exp = exp;
        sb_b.push_back(e);
        chk_b = 1'b1;
        @(posedge clk); #1;
        chk_b = 1'b0;
    endtask

    initial begin
        // Preload: lane RAM holds its own index, except for a few marker entries.
        for (int i = 0; i < 16; i++) u_a.mem[i] = 8'(i);
        u_a.mem[5]  = 8'h11;
        u_a.mem[15] = 8'h3C;
        for (int i = 0; i < 16384; i++) u_b.mem[i] = '0;

        @(posedge clk); #1;

        // During reset, q stays 0 and the write to address 3 is ignored.
        step_a("reset_q0",      1'b1, 1'b1, 4'd3,  8'hFF, 4'd3,  8'h00);
        step_a("reset_q1",      1'b1, 1'b1, 4'd3,  8'hFF, 4'd3,  8'h00);
        step_a("reset_nowrite", 1'b0, 1'b0, 4'd0,  8'h00, 4'd3,  8'h03);
        // Basic write followed by a read.
        step_a("wr_a5",         1'b0, 1'b1, 4'd3,  8'hA5, 4'd0,  8'h00);
        step_a("rd_a5",         1'b0, 1'b0, 4'd0,  8'h00, 4'd3,  8'hA5);
        // Read and write to the same address in one cycle: the read returns the old data.
        step_a("rdw_old",       1'b0, 1'b1, 4'd5,  8'h22, 4'd5,  8'h11);
        step_a("rdw_new",       1'b0, 1'b0, 4'd0,  8'h00, 4'd5,  8'h22);
        // Read and write to different addresses in one cycle.
        step_a("indep_rd15",    1'b0, 1'b1, 4'd0,  8'h7F, 4'd15, 8'h3C);
        step_a("indep_rd0",     1'b0, 1'b0, 4'd0,  8'h00, 4'd0,  8'h7F);
        // Boundary addresses with all-ones and all-zeros patterns.
        step_a("bnd_w0_ff",     1'b0, 1'b1, 4'd0,  8'hFF, 4'd1,  8'h01);
        step_a("bnd_r0_ff",     1'b0, 1'b1, 4'd15, 8'h00, 4'd0,  8'hFF);
        step_a("bnd_r15_00",    1'b0, 1'b1, 4'd0,  8'h00, 4'd15, 8'h00);
        step_a("bnd_r0_00",     1'b0, 1'b1, 4'd15, 8'hFF, 4'd0,  8'h00);
        step_a("bnd_r15_ff",    1'b0, 1'b0, 4'd0,  8'h00, 4'd15, 8'hFF);
        step_a("no_alias_14",   1'b0, 1'b0, 4'd0,  8'h00, 4'd14, 8'h0E);

        // Tag-array configuration.
        step_b("tag_wr_top",  1'b1, 14'd16383, 11'h5FF, 14'd0,     11'h000);
        step_b("tag_rd_top",  1'b0, 14'd0,     11'h000, 14'd16383, 11'h5FF);
        step_b("tag_rd_zero", 1'b0, 14'd0,     11'h000, 14'd0,     11'h000);

        // Wait a bounded number of cycles for the scoreboards to drain.
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", sb_a.size(), sb_b.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
